// File: rtl/uart_rx_monitor.sv
// UART receiver (8N1, LSB first) with a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_sync1, r_sync2;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_byte_ok, w_frame_err, w_par_err, w_par_bad;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [7:0]    r_rd_data, w_head_nxt;
    logic          r_empty, r_full, w_empty_nxt, w_full_nxt;
    logic          w_pop, w_push, w_overrun;
    logic          r_frame_err, r_overrun, r_parity_err;

`ifdef UART_RX_PARITY_EN
    logic r_par, w_par_nxt;

    function automatic logic f_even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    assign w_par_bad = (r_par != f_even_parity(r_shift));
`else
    assign w_par_bad = 1'b0;
`endif

    // Two-flop synchronizer; the line idles high so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state and bit-timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // Next-state logic: sample mid-start-bit, then once per bit period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_ok   = 1'b0;
        w_frame_err = 1'b0;
        w_par_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (!r_sync2) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt          = CNT_ZERO;
                    w_shift_nxt[r_idx] = r_sync2;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_par_nxt   = r_sync2;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (r_sync2) begin
                        w_state_nxt = ST_IDLE;
                        if (w_par_bad) begin
                            w_par_err = 1'b1;
                        end else begin
                            w_byte_ok = 1'b1;
                        end
                    end else begin
                        // Framing error wins over parity; wait out the break.
                        w_frame_err = 1'b1;
                        w_state_nxt = ST_WAIT_HI;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_WAIT_HI: begin
                w_cnt_nxt = CNT_ZERO;
                if (r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            default: begin
                w_cnt_nxt   = CNT_ZERO;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO control; the head is precomputed so rd_data_o can be a flop.
    always_comb begin
        w_pop       = rd_en_i && !r_empty;
        w_push      = w_byte_ok && (!r_full || w_pop);
        w_overrun   = w_byte_ok && r_full && !w_pop;
        w_wptr_nxt  = w_push ? (r_wptr + PTR_ONE) : r_wptr;
        w_rptr_nxt  = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
        w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
        w_full_nxt  = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                      (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
        if (w_empty_nxt) begin
            w_head_nxt = 8'h00;
        end else if (w_push && (r_wptr[AW-1:0] == w_rptr_nxt[AW-1:0])) begin
            w_head_nxt = r_shift;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt[AW-1:0]];
        end
    end

    // FIFO storage, pointers and registered status/head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_data <= 8'h00;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= r_shift;
            end
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_rd_data <= w_head_nxt;
            r_empty   <= w_empty_nxt;
            r_full    <= w_full_nxt;
        end
    end

    // Single-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_err;
            r_overrun    <= w_overrun;
            r_parity_err <= w_par_err;
        end
    end

    assign rd_data_o    = r_rd_data;
    assign empty_o      = r_empty;
    assign full_o       = r_full;
    assign frame_err_o  = r_frame_err;
    assign overrun_o    = r_overrun;
    assign parity_err_o = r_parity_err;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Randomized bench for uart_rx_monitor against a queue-based reference model.
// Honours UART_RX_PARITY_EN to build 8E1 frames and run the parity cases.
module tb_uart_rx_monitor;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Cycle (counted from start-bit edge) whose rising edge samples the stop bit.
    localparam int STOP_EDGE = 3 + CPB / 2 + CPB * (NB - 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, frame_err, overrun, parity_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_q[$];

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx_i   (uart_rx),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .empty_o     (empty),
        .full_o      (full),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .parity_err_o(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model_state(input string tag);
        check_val({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check_val({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check_val({tag, "_head"}, 32'(rd_data), 32'((model_q.size() > 0) ? model_q[0] : 8'h00));
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check_val({tag, "_flags"}, 32'({empty, full, frame_err, overrun, parity_err}), 32'b10000);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input logic pop_at_stop, input int extra_low);
        logic [10:0] bits;
        int   fe_n, ov_n, pe_n, size0;
        logic valid_pop, exp_push, exp_ov, exp_fe, exp_pe, first_head;
        fe_n = 0; ov_n = 0; pe_n = 0;
        size0 = model_q.size();
        bits = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_b;
        exp_pe   = stop_b && par_flip;
`else
        bits[9]  = stop_b;
        exp_pe   = 1'b0 & par_flip;
`endif
        exp_fe     = !stop_b;
        valid_pop  = pop_at_stop && (size0 > 0);
        exp_push   = stop_b && !exp_pe && ((size0 < DEPTH) || valid_pop);
        exp_ov     = stop_b && !exp_pe && !exp_push;
        first_head = exp_push && (size0 == 0);
        for (int c = 0; c < NB * CPB + extra_low; c++) begin
            @(negedge clk);
            fe_n += int'(frame_err);
            ov_n += int'(overrun);
            pe_n += int'(parity_err);
            if (c == STOP_EDGE - 1 && first_head) check_val("latency_still_empty", 32'(empty), 32'h1);
            if (c == STOP_EDGE) begin
                check_val("pulse_at_stop", 32'({frame_err, overrun, parity_err}),
                          32'({exp_fe, exp_ov, exp_pe}));
                if (first_head) begin
                    check_val("latency_empty_fall", 32'(empty), 32'h0);
                    check_val("latency_head", 32'(rd_data), 32'(d));
                end
            end
            uart_rx = (c < NB * CPB) ? bits[c / CPB] : 1'b0;
            rd_en   = pop_at_stop && (c == STOP_EDGE - 1);
        end
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        repeat (6) begin
            @(negedge clk);
            fe_n += int'(frame_err);
            ov_n += int'(overrun);
            pe_n += int'(parity_err);
        end
        check_val("frame_err_count", 32'(fe_n), 32'(exp_fe));
        check_val("overrun_count", 32'(ov_n), 32'(exp_ov));
        check_val("parity_err_count", 32'(pe_n), 32'(exp_pe));
        if (valid_pop) void'(model_q.pop_front());
        if (exp_push) model_q.push_back(d);
        check_model_state("after_frame");
    endtask

    task automatic pop_check();
        @(negedge clk);
        check_val("pop_head", 32'(rd_data), 32'((model_q.size() > 0) ? model_q[0] : 8'h00));
        check_val("pop_empty_before", 32'(empty), 32'(model_q.size() == 0));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        check_model_state("after_pop");
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] v;
        logic       stop_b, pflip, pas;
        int         fe_n, npop;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("post_reset");

        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0);
        pop_check();
        pop_check();

        // Short low glitch on an idle line must be ignored silently.
        fe_n = 0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            fe_n += int'(frame_err);
            uart_rx = (c < 4) ? 1'b0 : 1'b1;
        end
        check_val("glitch_no_frame_err", 32'(fe_n), 32'h0);
        check_model_state("glitch");

        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 40);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
        pop_check();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 0);
        repeat (DEPTH) pop_check();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h05, 1'b1, 1'b0, 1'b1, 0);
        repeat (DEPTH + 1) pop_check();

        // Reset in the middle of a frame with data already buffered.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
        v = 8'h99;
        for (int c = 0; c < 4 * CPB; c++) begin
            @(negedge clk);
            uart_rx = (c < CPB) ? 1'b0 : v[c / CPB - 1];
        end
        @(negedge clk);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        model_q.delete();
        #1;
        check_reset_vals("midframe_reset");
        repeat (3) @(negedge clk);
        check_reset_vals("midframe_reset_hold");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 0);
        pop_check();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 0);
        pop_check();
`endif

        for (int i = 0; i < 40; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            pflip  = ($urandom_range(0, 5) == 0);
`else
            pflip  = 1'b0;
`endif
            pas    = ($urandom_range(0, 3) == 0);
            send_frame(d, stop_b, pflip, pas, stop_b ? 0 : int'($urandom_range(0, 20)));
            npop = int'($urandom_range(0, 2));
            repeat (npop) pop_check();
        end
        repeat (DEPTH + 1) pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
